// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream/downstream handshake bundle for alu_result_stage.
interface alu_result_stage_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_result;
   logic [2:0]       in_select;
   logic             in_cout;
   logic             in_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_result;
   logic [2:0]       out_select;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_ovf;
   logic [1:0]       level;
   logic [CNT_W-1:0] accepted;

   modport slave (
      input  in_valid, in_result, in_select, in_cout, in_ovf, out_ready,
      output in_ready, out_valid, out_result, out_select,
             out_zero, out_neg, out_carry, out_ovf, level, accepted
   );

   modport master (
      output in_valid, in_result, in_select, in_cout, in_ovf, out_ready,
      input  in_ready, out_valid, out_result, out_select,
             out_zero, out_neg, out_carry, out_ovf, level, accepted
   );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered ALU result stage with 2-entry valid/ready FIFO,
// push-time status flags and a saturating accepted-push counter.
// Optional feature macro: ALU_RESULT_FLAGS_EN (flag storage; flags read 0 when undefined).
module alu_result_stage #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   alu_result_stage_if.slave   bus
);
   localparam logic [2:0]       SEL_ADD = 3'b010;
   localparam logic [2:0]       SEL_SUB = 3'b100;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             push_c, pop_c, in_ready_c, out_valid_c;
   logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [W-1:0]     res_q [2];
   logic [W-1:0]     res_d [2];
   logic [2:0]       sel_q [2];
   logic [2:0]       sel_d [2];
   logic [W-1:0]     out_result_q, out_result_d;
   logic [2:0]       out_select_q, out_select_d;
   logic [CNT_W-1:0] accepted_q, accepted_d;
`ifdef ALU_RESULT_FLAGS_EN
   // flag order: {zero, neg, carry, ovf}
   logic [3:0]       flg_q [2];
   logic [3:0]       flg_d [2];
   logic [3:0]       out_flg_q, out_flg_d;
   logic [3:0]       new_flg_c;
   logic             arith_c;
`endif

   // Occupancy state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Occupancy next-state: simultaneous push and pop leaves the level unchanged.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (push_c) state_d = ST_ONE;
         ST_ONE: begin
            if (push_c && !pop_c)      state_d = ST_FULL;
            else if (!push_c && pop_c) state_d = ST_EMPTY;
         end
         ST_FULL:  if (pop_c) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Handshake decode from registered state only.
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      in_ready_c  = (state_q != ST_FULL);
      out_valid_c = (state_q != ST_EMPTY);
      push_c      = bus.in_valid && in_ready_c;
      pop_c       = out_valid_c && bus.out_ready;
   end

   // FIFO storage, pointers, head capture and counter next values.
   always_comb begin
      res_d        = res_q;
      sel_d        = sel_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      out_result_d = out_result_q;
      out_select_d = out_select_q;
      accepted_d   = accepted_q;
`ifdef ALU_RESULT_FLAGS_EN
      flg_d        = flg_q;
      out_flg_d    = out_flg_q;
      arith_c      = (bus.in_select == SEL_ADD) || (bus.in_select == SEL_SUB);
      new_flg_c    = {(bus.in_result == '0), bus.in_result[W-1],
                      arith_c && bus.in_cout, arith_c && bus.in_ovf};
`endif
      if (push_c) begin
         res_d[wr_ptr_q] = bus.in_result;
         sel_d[wr_ptr_q] = bus.in_select;
`ifdef ALU_RESULT_FLAGS_EN
         flg_d[wr_ptr_q] = new_flg_c;
`endif
         wr_ptr_d        = ~wr_ptr_q;
         if (accepted_q != CNT_MAX) accepted_d = accepted_q + CNT_W'(1);
      end
      if (pop_c) rd_ptr_d = ~rd_ptr_q;
      // Head registers follow the next head entry; they hold when the FIFO drains.
      if (state_d != ST_EMPTY) begin
         out_result_d = res_d[rd_ptr_d];
         out_select_d = sel_d[rd_ptr_d];
`ifdef ALU_RESULT_FLAGS_EN
         out_flg_d    = flg_d[rd_ptr_d];
`endif
      end
   end

   // Datapath registers; reset discards buffered entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q        <= '{default: '0};
         sel_q        <= '{default: '0};
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         out_result_q <= '0;
         out_select_q <= '0;
         accepted_q   <= '0;
`ifdef ALU_RESULT_FLAGS_EN
         flg_q        <= '{default: '0};
         out_flg_q    <= '0;
`endif
      end else begin
         res_q        <= res_d;
         sel_q        <= sel_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         out_result_q <= out_result_d;
         out_select_q <= out_select_d;
         accepted_q   <= accepted_d;
`ifdef ALU_RESULT_FLAGS_EN
         flg_q        <= flg_d;
         out_flg_q    <= out_flg_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.level      = state_q;
   assign bus.accepted   = accepted_q;
   assign bus.out_result = out_result_q;
   assign bus.out_select = out_select_q;
`ifdef ALU_RESULT_FLAGS_EN
   assign bus.out_zero   = out_flg_q[3];
   assign bus.out_neg    = out_flg_q[2];
   assign bus.out_carry  = out_flg_q[1];
   assign bus.out_ovf    = out_flg_q[0];
`else
   assign bus.out_zero   = 1'b0;
   assign bus.out_neg    = 1'b0;
   assign bus.out_carry  = 1'b0;
   assign bus.out_ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed + randomized bench with a queue-based reference model.
module tb_alu_result_stage;
   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned CNT_S = 4;
`ifdef ALU_RESULT_FLAGS_EN
   localparam bit FLG = 1'b1;
`else
   localparam bit FLG = 1'b0;
`endif
   localparam logic [2:0] MOV = 3'b000, ADD = 3'b010, NOR = 3'b011,
                          SUB = 3'b100, AND = 3'b110;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_result_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();
   alu_result_stage_if #(.W(W), .CNT_W(CNT_S)) sbus ();

   alu_result_stage #(.W(W), .CNT_W(CNT_W)) dut     (.clk(clk), .rst(rst), .bus(bus));
   alu_result_stage #(.W(W), .CNT_W(CNT_S)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

   typedef struct {
      logic [W-1:0] r;
      logic [2:0]   s;
      logic         z, n, c, o;
   } ent_t;

   ent_t q[$];
   ent_t last;
   int   acc, sat_acc;
   int   checks = 0;
   int   errors = 0;

   function automatic ent_t mk(logic [W-1:0] r, logic [2:0] s, logic co, logic ov);
      ent_t e;
      bit   arith;
      arith = (s == ADD) || (s == SUB);
      e.r = r;
      e.s = s;
      e.z = FLG && (r == 0);
      e.n = FLG && r[W-1];
      e.c = FLG && arith && co;
      e.o = FLG && arith && ov;
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last    = '{default: '0};
      acc     = 0;
      sat_acc = 0;
   endtask

   task automatic check_all(string tag);
      ent_t h;
      h = (q.size() > 0) ? q[0] : last;
      chk({tag, ".in_ready"},  64'(bus.in_ready),   64'(q.size() < 2));
      chk({tag, ".out_valid"}, 64'(bus.out_valid),  64'(q.size() > 0));
      chk({tag, ".level"},     64'(bus.level),      64'(q.size()));
      chk({tag, ".accepted"},  64'(bus.accepted),   64'(acc));
      chk({tag, ".result"},    64'(bus.out_result), 64'(h.r));
      chk({tag, ".select"},    64'(bus.out_select), 64'(h.s));
      chk({tag, ".flags"},
          64'({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf}),
          64'({h.z, h.n, h.c, h.o}));
      chk({tag, ".sat_acc"},   64'(sbus.accepted),  64'(sat_acc));
   endtask

   task automatic drive(bit v, logic [W-1:0] r, logic [2:0] s, bit co, bit ov, bit rdy);
      bus.in_valid  = v;
      bus.in_result = r;
      bus.in_select = s;
      bus.in_cout   = co;
      bus.in_ovf    = ov;
      bus.out_ready = rdy;
   endtask

   // One clock: model decides push/pop from pre-edge state, then outputs are checked.
   task automatic tick(string tag);
      bit push, pop;
      ent_t e;
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && bus.out_ready;
      e    = mk(bus.in_result, bus.in_select, bus.in_cout, bus.in_ovf);
      @(posedge clk);
      if (pop) last = q.pop_front();
      if (push) begin
         q.push_back(e);
         if (acc < (1 << CNT_W) - 1) acc++;
      end
      if (sbus.in_valid && sat_acc < (1 << CNT_S) - 1) sat_acc++;
      #1;
      check_all(tag);
   endtask

   // Reset asserted between clock edges and checked before any edge.
   task automatic async_reset(string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, '0, MOV, 0, 0, 0);
      sbus.in_valid  = 1'b0;
      sbus.out_ready = 1'b1;
      sbus.in_result = 32'h0000_0001;
      sbus.in_select = AND;
      sbus.in_cout   = 1'b1;
      sbus.in_ovf    = 1'b1;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single ADD of zero with carry, consumer stalled
      drive(1, 32'h0000_0000, ADD, 1, 0, 0);
      tick("add");
      chk("add.zero_c",  64'(bus.out_zero),  64'(FLG));
      chk("add.carry_c", 64'(bus.out_carry), 64'(FLG));
      chk("add.level_c", 64'(bus.level),     64'd1);

      // Second push then reset mid-stream
      drive(1, 32'h0000_1234, MOV, 0, 0, 0);
      tick("mid_push");
      drive(0, '0, MOV, 0, 0, 0);
      async_reset("rst_mid");
      chk("rst_mid.level_c", 64'(bus.level), 64'd0);

      // Fill and stall; third push must be dropped
      drive(1, 32'h8000_0000, SUB, 0, 1, 0);
      tick("fill_sub");
      drive(1, 32'h0000_0001, NOR, 1, 1, 0);
      tick("fill_nor");
      chk("fill.in_ready_c", 64'(bus.in_ready), 64'd0);
      drive(1, 32'h0000_dead, MOV, 0, 0, 0);
      tick("fill_drop");
      chk("fill.accepted_c", 64'(bus.accepted), 64'd2);
      chk("fill.sub_neg_c",  64'(bus.out_neg),  64'(FLG));
      chk("fill.sub_ovf_c",  64'(bus.out_ovf),  64'(FLG));
      drive(0, '0, MOV, 0, 0, 1);
      tick("drain_sub");
      chk("drain.nor_sel_c",   64'(bus.out_select), 64'(NOR));
      chk("drain.nor_carry_c", 64'(bus.out_carry),  64'd0);
      tick("drain_nor");
      tick("drain_idle");

      // Flag masking for a non-arithmetic op
      drive(1, 32'hffff_ffff, AND, 1, 1, 1);
      tick("mask_and");
      chk("mask.carry_c", 64'(bus.out_carry), 64'd0);
      chk("mask.ovf_c",   64'(bus.out_ovf),   64'd0);
      drive(0, '0, MOV, 0, 0, 1);
      tick("mask_drain");

      // Back-to-back streaming with out_ready held high
      drive(0, '0, MOV, 0, 0, 1);
      async_reset("rst_b2b");
      for (int i = 0; i < 100; i++) begin
         drive(1, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1);
         tick("b2b");
         chk("b2b.level_c", 64'(bus.level), 64'd1);
      end
      chk("b2b.accepted_c", 64'(bus.accepted), 64'd100);
      drive(0, '0, MOV, 0, 0, 1);
      tick("b2b_drain");

      // Randomized traffic with random stalls
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 5) == 0) ? '0 : $urandom,
               3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0));
         tick("rand");
      end

      // Counter saturation on the narrow-counter instance
      drive(0, '0, MOV, 0, 0, 1);
      async_reset("rst_sat");
      sbus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) tick("sat");
      chk("sat.accepted_c", 64'(sbus.accepted), 64'd15);
      chk("sat.flags_c",
          64'({sbus.out_zero, sbus.out_neg, sbus.out_carry, sbus.out_ovf}), 64'd0);
      sbus.in_valid = 1'b0;
      tick("sat_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the per-bit ALU result multiplexers. It captures the assembled W-bit ALU result and its 3-bit operation select, and derives status flags. It buffers up to two results in a valid/ready FIFO so the ALU can issue back-to-back while the consumer (register-file write port or testbench monitor) stalls. A saturating counter records how many results have been accepted.

## Interface
- W, 32: result width; equals the number of per-bit mux slices feeding this stage.
- CNT_W, 16: width of the accepted-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  stage can accept; equals not-full.
- in_result  input  W  concatenated per-bit mux outputs.
- in_select  input  3  operation select that produced in_result.
- in_cout  input  1  carry-out of the adder chain; meaningful for ADD and SUB only.
- in_ovf  input  1  signed overflow of the adder chain; meaningful for ADD and SUB only.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_result  output  W  head result.
- out_select  output  3  head select.
- out_zero, out_neg, out_carry, out_ovf  output  1 each  head flags.
- level  output  2  occupancy, 0..2.
- accepted  output  CNT_W  number of accepted pushes, saturating.

## Operation
- Select encoding: 000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 SLT.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Flags are computed at push time and stored with the entry:
  - zero = (in_result == 0).
  - neg = in_result[W-1].
  - carry = in_cout if select is 010 or 100, else 0.
  - ovf = in_ovf if select is 010 or 100, else 0.
- FIFO has two entries, a 1-bit read pointer, a 1-bit write pointer and a 2-bit level.
- Pointers wrap 1→0.
- Head outputs are driven from the read-pointer entry.
- Occupancy states: EMPTY (level 0), ONE (level 1), FULL (level 2).
  - EMPTY: push→ONE. Pop is impossible because out_valid=0.
  - ONE: push only→FULL. Pop only→EMPTY. Push and pop together→ONE, with the new entry becoming head on the next cycle.
  - FULL: in_ready=0, so no push. Pop→ONE. A push while FULL is ignored and its data dropped; the upstream must hold it.
- accepted increments on each push and holds at 2^CNT_W−1.
- Reset (asynchronous, any time, including mid-transfer):
  - level=0, pointers=0, accepted=0.
  - out_valid=0, in_ready=1.
  - out_result=0, out_select=000, all flags 0.
  - Buffered entries are discarded.

## Timing
- Latency is 1 cycle: data pushed at edge N appears on out_* with out_valid=1 after edge N.
- There is no combinational path from in_* to out_*, and none from out_ready to in_ready. in_ready depends only on registered level.
- Peak throughput is 1 result per cycle when out_ready is held high.
- Outputs are stable while out_valid=1 and out_ready=0.
- When empty, out_result, out_select and the flags hold their last-popped values, except after reset, when they are 0.

## Configuration
- ALU_RESULT_FLAGS_EN:
  - Defined: flags are computed and stored as described above.
  - Undefined: no flag storage is built; out_zero, out_neg, out_carry and out_ovf are tied to 0; in_cout and in_ovf are unused. FIFO, handshake and counter behaviour are unchanged.

## Test plan
- Reset mid-stream: push 2 entries, then assert rst between edges → out_valid=0, level=0, in_ready=1, accepted=0 immediately, with no clock required.
- Single ADD: in_result=0x0000_0000, select=010, cout=1, ovf=0, out_ready=0 → next cycle out_valid=1, zero=1, carry=1, neg=0, level=1.
- Fill and stall: push SUB 0x8000_0000 (ovf=1), then NOR 0x1; out_ready=0 → level=2, in_ready=0. A third push is ignored and accepted=2. Raise out_ready → SUB pops first with neg=1 and ovf=1, then NOR with carry=0.
- Simultaneous push and pop at level 1, repeated over 100 cycles with out_ready=1 → level stays 1, results come out in order with 1-cycle latency, accepted=100.
- Flag masking: AND with cout=1 and ovf=1 → out_carry=0, out_ovf=0.
- Saturation with CNT_W=4: make 20 pushes → accepted=15. With ALU_RESULT_FLAGS_EN undefined, all flag outputs remain 0.
